// File: rtl/sbox_arbiter.sv
`default_nettype none
// =============================================================================
// sbox_arbiter : round-robin sharing of one S-box memory among N_REQ requesters,
// sequencing the memory's address/data flag handshake.
// Optional watchdog abort: define SBOX_TIMEOUT_EN.                  Rev 1.0
// =============================================================================
module sbox_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    flag_address_sent,
  input  logic                    addr_ack,
  input  logic [DATA_W-1:0]       sbox_read,
  input  logic                    flag_data_sent,
  output logic                    data_ack
);

  localparam int              IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0]  N_REQ_W = (IDX_W+1)'(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_DONE      = 3'd3
`ifdef SBOX_TIMEOUT_EN
    , S_ERR     = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [2*N_REQ-1:0] req_rot;
  logic               pick_found;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  pick_addr;
  logic [IDX_W:0]     rr_inc;
  logic [IDX_W-1:0]   rr_next;
  logic               rsp_pulse;
  logic               timeout_hit;

  // Rotating the doubled request vector by rr_q puts the search start at bit 0.
  always_comb begin
    req_rot    = {req, req} >> rr_q;
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_q} + (IDX_W+1)'(i);
      end
    end
    if (pick_sum >= N_REQ_W) pick_sum = pick_sum - N_REQ_W;
    pick_idx  = pick_sum[IDX_W-1:0];
    pick_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
    rr_inc  = {1'b0, idx_q} + (IDX_W+1)'(1);
    rr_next = (rr_inc >= N_REQ_W) ? '0 : rr_inc[IDX_W-1:0];
  end

`ifdef SBOX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero in IDLE, so it is already clear on entry to ADDR.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_ADDR || state_q == S_WAIT_DATA) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          addr_d  = pick_addr;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (addr_ack) begin
          state_d = S_WAIT_DATA;
        end
`ifdef SBOX_TIMEOUT_EN
        else if (timeout_hit) begin
          data_d  = '0;
          state_d = S_ERR;
        end
`endif
      end
      S_WAIT_DATA: begin
        if (flag_data_sent) begin
          data_d  = sbox_read;
          state_d = S_DONE;
        end
`ifdef SBOX_TIMEOUT_EN
        else if (timeout_hit) begin
          data_d  = '0;
          state_d = S_ERR;
        end
`endif
      end
      S_DONE: begin
        rr_d    = rr_next;
        state_d = S_IDLE;
      end
`ifdef SBOX_TIMEOUT_EN
      S_ERR: begin
        rr_d    = rr_next;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    busy              = (state_q != S_IDLE);
    flag_address_sent = (state_q == S_ADDR);
    data_ack          = (state_q == S_DONE);
`ifdef SBOX_TIMEOUT_EN
    rsp_err           = (state_q == S_ERR);
`else
    rsp_err           = 1'b0;
`endif
    rsp_pulse         = data_ack | rsp_err;
    gnt               = '0;
    rsp_valid         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i]       = busy && (idx_q == IDX_W'(i));
      rsp_valid[i] = rsp_pulse && (idx_q == IDX_W'(i));
    end
    mem_addr = addr_q;
    rsp_data = data_q;
  end

  logic unused_hit;
  assign unused_hit = timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_sbox_arbiter.sv
`default_nettype none
// tb_sbox_arbiter : randomized requesters and memory, transaction-level reference
// model feeding a scoreboard that a separate monitor drains.
module tb_sbox_arbiter;
  localparam int N_REQ = 2;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TO = 10;

  logic                    clk, rst;
  logic [N_REQ-1:0]        req, gnt, rsp_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]       rsp_data, sbox_read;
  logic                    rsp_err, busy, flag_address_sent, addr_ack, flag_data_sent, data_ack;
  logic [ADDR_W-1:0]       mem_addr;

  sbox_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .mem_addr(mem_addr),
    .flag_address_sent(flag_address_sent), .addr_ack(addr_ack), .sbox_read(sbox_read),
    .flag_data_sent(flag_data_sent), .data_ack(data_ack));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  logic [7:0] tbl [256];

  typedef struct { int idx; logic [7:0] addr; logic [7:0] data; bit err; int t0; } exp_t;
  exp_t sb_q[$];
  int   hist[$];

  task automatic check(string nm, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [N_REQ-1:0] oh(int i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- memory model ----------------
  int mem_mode = 0;
  int acnt, dcnt, cur_a, cur_w, mst;
  bit early, noack;
  logic [7:0] maddr;

  task automatic mem_reload();
    noack = (mem_mode == 3);
    case (mem_mode)
      0: begin acnt = 0; dcnt = 0; early = 0; end
      1: begin acnt = $urandom_range(0, 4); dcnt = $urandom_range(0, 4); early = ($urandom_range(0, 3) == 0); end
      2: begin acnt = 5; dcnt = 3; early = 0; end
      default: begin acnt = 0; dcnt = 20; early = 0; end
    endcase
    cur_a = acnt;
    cur_w = early ? 1 : dcnt + 1;
  endtask

  initial begin
    addr_ack = 0; flag_data_sent = 0; sbox_read = 0; mst = 0; maddr = 0;
    mem_reload();
    forever begin
      @(negedge clk);
      if (rst) begin
        addr_ack = 0; flag_data_sent = 0; mst = 0; mem_reload();
      end else begin
        if (!flag_address_sent) addr_ack = 0;
        case (mst)
          0: if (flag_address_sent && !noack) begin
               if (acnt == 0) begin
                 addr_ack = 1; maddr = mem_addr;
                 if (early) begin flag_data_sent = 1; sbox_read = tbl[maddr]; mst = 2; end
                 else mst = 1;
               end else acnt--;
             end
          1: if (!flag_address_sent) begin
               if (dcnt == 0) begin flag_data_sent = 1; sbox_read = tbl[maddr]; mst = 2; end
               else dcnt--;
             end
          default: if (data_ack) begin
               flag_data_sent = 0; sbox_read = 8'($urandom); mst = 0; mem_reload();
             end
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  int fa_cnt = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin fa_cnt = 0; continue; end
      check("gnt", 32'(gnt), 32'((sb_q.size() != 0) ? oh(sb_q[0].idx) : '0));
      check("busy", 32'(busy), 32'(sb_q.size() != 0));
      if (flag_address_sent) begin
        fa_cnt++;
        if (sb_q.size() != 0) check("mem_addr", 32'(mem_addr), 32'(sb_q[0].addr));
      end
      if (rsp_valid != 0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          hist.push_back(e.idx);
          check("rsp_valid", 32'(rsp_valid), 32'(oh(e.idx)));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_data", 32'(rsp_data), e.err ? 32'h0 : 32'(e.data));
          check("data_ack", 32'(data_ack), 32'(!e.err));
          check("latency", 32'(cyc - e.t0), e.err ? 32'(TO + 1) : 32'(cur_a + 2 + cur_w));
          check("addr_phase_len", 32'(fa_cnt), e.err ? 32'(TO) : 32'(cur_a + 1));
        end
        fa_cnt = 0;
      end else begin
        check("idle_data_ack", 32'(data_ack), 32'h0);
        check("idle_rsp_err", 32'(rsp_err), 32'h0);
      end
    end
  end

  // ---------------- stimulus + reference model ----------------
  bit model_free = 1, pend_free = 0, rnd = 0, cont = 0, expect_to = 0;
  int rr_m = 0;

  task automatic tick();
    if (pend_free) begin model_free = 1; pend_free = 0; end
    if (rsp_valid != 0) pend_free = 1;
    for (int i = 0; i < N_REQ; i++) begin
      if (rsp_valid[i] && !cont) req[i] = 1'b0;
      if (rnd) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1; req_addr[i*ADDR_W +: ADDR_W] = 8'($urandom);
        end else if (req[i] && gnt[i] && $urandom_range(0, 7) == 0) begin
          req_addr[i*ADDR_W +: ADDR_W] = 8'($urandom);
        end else if (req[i] && gnt[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    if (model_free && !rst && req != 0) begin
      for (int k = 0; k < N_REQ; k++) begin
        int j;
        j = (rr_m + k) % N_REQ;
        if (model_free && req[j]) begin
          exp_t e;
          e.idx = j; e.addr = req_addr[j*ADDR_W +: ADDR_W]; e.data = tbl[e.addr];
          e.err = expect_to; e.t0 = cyc;
          sb_q.push_back(e);
          rr_m = (j + 1) % N_REQ;
          model_free = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    tick();
  endtask

  task automatic drain(int budget, string nm);
    int n = 0;
    while ((sb_q.size() != 0 || req != 0) && n < budget) begin step(); n++; end
    check(nm, 32'(n >= budget), 32'h0);
  endtask

  task automatic flush_model();
    sb_q.delete(); model_free = 1; pend_free = 0; rr_m = 0; req = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    flush_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(string nm);
    check({nm, "_outs"}, {8'(gnt), 8'(rsp_valid), 6'd0, rsp_err, busy, flag_address_sent, data_ack, 6'd0},
          32'h0);
    check({nm, "_data_addr"}, {16'(rsp_data), 16'(mem_addr)}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0;
    for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
    tbl[8'h53] = 8'hED; tbl[8'h00] = 8'h63; tbl[8'h01] = 8'h7C;
    @(posedge clk); #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single lookup, fast memory
    mem_mode = 0; mem_reload();
    @(negedge clk); req_addr[7:0] = 8'h53; req = 2'b01; tick();
    drain(50, "single_timeout");

    // contention from a fresh round-robin pointer
    apply_reset();
    hist.delete();
    @(negedge clk); req_addr = {8'h01, 8'h00}; cont = 1; req = 2'b11; tick();
    repeat (16) step();
    @(negedge clk); cont = 0; req = '0; tick();
    drain(50, "contention_timeout");
    check("contention_count", 32'(hist.size() >= 4), 32'h1);
    for (int k = 0; k < hist.size(); k++) check("contention_order", 32'(hist[k]), 32'(k % 2));

    // slow memory
    mem_mode = 2; mem_reload();
    @(negedge clk); req_addr[15:8] = 8'($urandom); req = 2'b10; tick();
    drain(60, "slow_timeout");

    // randomized traffic and memory timing
    mem_mode = 1; mem_reload();
    rnd = 1;
    repeat (1500) step();
    rnd = 0;
    drain(600, "random_drain_timeout");

    // reset while waiting for data
    mem_mode = 0; mem_reload();
    @(negedge clk); req_addr[7:0] = 8'($urandom); req = 2'b01; tick();
    drain(50, "pre_reset_timeout");
    mem_mode = 4; mem_reload();
    @(negedge clk); req_addr[15:8] = 8'($urandom); req = 2'b10; tick();
    begin
      int n = 0;
      while (!(gnt != 0 && !flag_address_sent && busy) && n < 50) begin step(); n++; end
      check("reach_wait_data", 32'(n >= 50), 32'h0);
    end
    #2 rst = 1'b1;
    flush_model();
    #1 check_all_zero("reset_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_mode = 0; mem_reload();
    hist.delete();
    @(negedge clk); req_addr = {8'h01, 8'h00}; req = 2'b11; tick();
    drain(50, "post_reset_timeout");
    check("post_reset_first_grant", 32'(hist.size() != 0 ? hist[0] : -1), 32'h0);

    // memory never acknowledges the address
    mem_mode = 3; mem_reload();
`ifdef SBOX_TIMEOUT_EN
    expect_to = 1;
    @(negedge clk); req_addr[7:0] = 8'($urandom); req = 2'b01; tick();
    drain(100, "timeout_abort_missing");
    expect_to = 0;
`else
    @(negedge clk); req_addr[7:0] = 8'($urandom); req = 2'b01; tick();
    repeat (1000) step();
    check("stall_busy", 32'(busy), 32'h1);
    check("stall_flag_address_sent", 32'(flag_address_sent), 32'h1);
    check("stall_no_response", 32'(sb_q.size()), 32'h1);
    apply_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sbox_arbiter.md
Name: sbox_arbiter

Overview:
Shares the single 256-entry S-box memory between several S-box requesters, e.g. the AES round SubBytes path and the key-expansion path. Each requester gets a round-robin grant. The block sequences the memory's two-phase address/data flag handshake and returns the looked-up byte to the granted requester. It sits between the aes core's S-box read requests and the memory block.

Parameters:
N_REQ, 2, number of requesters (1..8)
ADDR_W, 8, S-box address width
DATA_W, 8, S-box data width
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with SBOX_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester lookup request; held high with stable address until its rsp_valid
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
gnt  out  N_REQ  one-hot grant; high from ADDR through DONE/ERR
rsp_valid  out  N_REQ  one-cycle pulse to the granted requester
rsp_data  out  DATA_W  looked-up byte; valid while rsp_valid is high, held until the next response
rsp_err  out  1  high with rsp_valid on a timeout abort
busy  out  1  high whenever the state is not IDLE
mem_addr  out  ADDR_W  address to memory, stable while flag_address_sent is high
flag_address_sent  out  1  address-valid flag to memory
addr_ack  in  1  memory has accepted the address
sbox_read  in  DATA_W  data from memory
flag_data_sent  in  1  memory data-valid flag
data_ack  out  1  one-cycle data acknowledge to memory

Behaviour:
- Reset (async, immediate): state IDLE; rr_ptr=0; all outputs 0, including rsp_data. Reset during any state aborts the transaction with no response and no data_ack.
- States: IDLE, ADDR, WAIT_DATA, DONE, ERR.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - Latch its index and address, set gnt.
  - Go to ADDR on the next edge.
- ADDR:
  - flag_address_sent=1, mem_addr=latched address.
  - addr_ack=1 -> WAIT_DATA.
- WAIT_DATA:
  - flag_address_sent=0.
  - flag_data_sent=1 -> latch sbox_read into rsp_data, go to DONE.
  - A flag_data_sent that arrives while in ADDR is ignored until WAIT_DATA.
- DONE (one cycle):
  - data_ack=1, rsp_valid[idx]=1, rsp_err=0.
  - rr_ptr = idx+1, wrapping to 0 at N_REQ.
  - Go to IDLE.
- Minimum latency, with addr_ack and flag_data_sent already high:
  - req seen in IDLE at cycle 0.
  - ADDR at cycle 1.
  - WAIT_DATA at cycle 2.
  - rsp_valid at cycle 3.
  - Next grant decision at cycle 4. Throughput is at most 1 lookup per 4 cycles.
- Address and index are latched at grant. Changes to req_addr after grant have no effect.
- Requester drops req mid-transaction: the transaction still completes and rsp_valid still pulses; the requester ignores it.
- Simultaneous requests: exactly one grant. With all requesters asserting continuously, grants rotate 0,1,...,N_REQ-1,0.
- N_REQ=1: the arbiter degenerates to a pass-through sequencer; rr_ptr stays 0.

Optional Feature:
SBOX_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ADDR and increments each cycle in ADDR or WAIT_DATA.
  - When it reaches TIMEOUT_CYCLES without the awaited ack/flag, go to ERR.
  - ERR (one cycle): rsp_valid[idx]=1, rsp_err=1, rsp_data=0, data_ack=0, flag_address_sent=0; rr_ptr advances as in DONE; then IDLE.
- Undefined: no counter and no ERR state; the block waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single lookup: after reset, req=01, req_addr[7:0]=0x53; memory acks immediately and returns 0xED -> flag_address_sent cycle 1 with mem_addr=0x53, rsp_valid=01 and rsp_data=0xED at cycle 3, data_ack pulse in the same cycle.
- Contention: req=11 held, addresses 0x00 and 0x01, memory returns 0x63 and 0x7C -> grants alternate 01,10,01,10; response data matches each requester's address; no requester is skipped.
- Slow memory: addr_ack delayed 5 cycles, flag_data_sent a further 3 cycles -> flag_address_sent high exactly 6 cycles with mem_addr stable; one rsp_valid, one data_ack.
- Reset mid-operation: assert rst while in WAIT_DATA -> all outputs 0 immediately; no rsp_valid; the next request after reset is granted from requester 0.
- Timeout (with SBOX_TIMEOUT_EN, TIMEOUT_CYCLES=10): addr_ack never asserted -> ERR after 10 cycles in ADDR; rsp_valid with rsp_err=1 and rsp_data=0; no data_ack. Without the macro: still waiting after 1000 cycles.
